demux8_stream: RTL and testbench

// - Inverse of the 8:1 word mux: accepts one N-bit word stream and routes each

---
 rtl/demux8_pkg.sv | 25 ++
 rtl/demux8_stream_if.sv | 28 ++
 rtl/demux8_stream_lane.sv | 26 ++
 rtl/demux8_stream.sv | 68 ++++++
 tb/tb_demux8_stream.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/demux8_pkg.sv
// Shared types and helpers for the 8-lane stream demultiplexer.
package demux8_pkg;

    localparam int unsigned NUM_LANES  = 8;
    localparam int unsigned LANE_IDX_W = 3;
    localparam int unsigned COUNT_W    = 4;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_RR   = 1'b1
    } route_mode_t;

    // Number of set bits in a lane-valid vector (0..8).
    function automatic logic [COUNT_W-1:0] lane_count(input logic [NUM_LANES-1:0] v);
        logic [COUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            c = c + COUNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux8_stream_if.sv
// Producer-side input stream, per-lane consumer handshakes and status for demux8_stream.
interface demux8_stream_if #(
    parameter int unsigned N = 4
);
    import demux8_pkg::*;

    logic [N-1:0]                  in_data;
    lane_idx_t                     in_sel;
    logic                          in_valid;
    logic                          in_ready;
    logic                          mode;
    logic [NUM_LANES-1:0][N-1:0]   out_data;
    logic [NUM_LANES-1:0]          out_valid;
    logic [NUM_LANES-1:0]          out_ready;
    lane_idx_t                     rr_ptr;
    logic [COUNT_W-1:0]            pending;

    modport master (
        output in_data, in_sel, in_valid, mode, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, pending
    );

    modport slave (
        input  in_data, in_sel, in_valid, mode, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, pending
    );

endinterface

// File: rtl/demux8_stream_lane.sv
// One-entry lane holding register; a load wins over a drain in the same cycle.
module demux_lane #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] ld_data,
    input  logic         drain,
    output logic         valid,
    output logic [N-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux8_stream.sv
// Routes one word stream to 8 single-entry lanes, addressed or round-robin.
module demux8_stream
    import demux8_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            reset,
    demux8_stream_if.slave  bus
);

    route_mode_t                 mode_c;
    lane_idx_t                   dst_c;
    logic                        in_ready_c;
    logic                        accept_c;
    logic [NUM_LANES-1:0]        load_c;
    logic [NUM_LANES-1:0]        next_valid_c;
    logic [NUM_LANES-1:0]        valid;
    logic [NUM_LANES-1:0][N-1:0] data;
    lane_idx_t                   rr_ptr_q;
    logic [COUNT_W-1:0]          pending_q;

    assign mode_c = route_mode_t'(bus.mode);

    // Destination select and flow control; a draining full lane may be reloaded.
    always_comb begin
        dst_c      = (mode_c == MODE_RR) ? rr_ptr_q : bus.in_sel;
        in_ready_c = !valid[dst_c] || bus.out_ready[dst_c];
        accept_c   = bus.in_valid && in_ready_c;
        load_c     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            load_c[i] = accept_c && (dst_c == lane_idx_t'(i));
        end
        next_valid_c = load_c | (valid & ~bus.out_ready);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane #(.N(N)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (load_c[g]),
            .ld_data (bus.in_data),
            .drain   (bus.out_ready[g]),
            .valid   (valid[g]),
            .data    (data[g])
        );
    end

    // Pointer moves only on round-robin accepts; pending tracks the next lane occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (accept_c && (mode_c == MODE_RR)) begin
                rr_ptr_q <= rr_ptr_q + lane_idx_t'(1);
            end
            pending_q <= lane_count(next_valid_c);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid;
    assign bus.out_data  = data;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_demux8_stream.sv
// Directed and randomized bench for demux8_stream against a lane-array model with per-lane scoreboards.
module tb_demux8_stream;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    demux8_stream_if #(.N(4)) bus ();

    demux8_stream #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: which lanes hold a word, what each lane shows, and the round-robin pointer.
    logic [7:0] mvalid;
    logic [3:0] mdata [8];
    int         mrr;
    logic [3:0] sb [8][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mvalid = '0;
        mrr    = 0;
        for (int i = 0; i < 8; i++) begin
            mdata[i] = '0;
            sb[i].delete();
        end
    endtask

    task automatic check_state();
        logic [7:0][3:0] exp_data;
        for (int i = 0; i < 8; i++) exp_data[i] = mdata[i];
        check("out_valid", 32'(bus.out_valid), 32'(mvalid));
        check("out_data", 32'(bus.out_data), 32'(exp_data));
        check("rr_ptr", 32'(bus.rr_ptr), 32'(mrr));
        check("pending", 32'(bus.pending), 32'($countones(mvalid)));
        check("pending_pop", 32'(bus.pending), 32'($countones(bus.out_valid)));
    endtask

    // One cycle: drive at edge+1, check at edge+3, advance the model at the edge.
    task automatic step(input logic v, input logic [2:0] sel, input logic [3:0] d,
                        input logic m, input logic [7:0] ordy, output logic rdy);
        int   dst;
        logic exp_rdy;
        logic acc;
        logic [3:0] front;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.mode      = m;
        bus.out_ready = ordy;
        #2;
        dst     = m ? mrr : int'(sel);
        exp_rdy = !mvalid[dst] || ordy[dst];
        rdy     = bus.in_ready;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_state();
        for (int i = 0; i < 8; i++) begin
            if (mvalid[i] && ordy[i]) begin
                check("sb_depth", 32'(sb[i].size()), 32'd1);
                if (sb[i].size() > 0) begin
                    front = sb[i].pop_front();
                    check("sb_word", 32'(bus.out_data[i]), 32'(front));
                end
            end
        end
        acc = v && exp_rdy;
        @(posedge clk);
        for (int i = 0; i < 8; i++) if (ordy[i]) mvalid[i] = 1'b0;
        if (acc) begin
            mvalid[dst] = 1'b1;
            mdata[dst]  = d;
            sb[dst].push_back(d);
            if (m) mrr = (mrr + 1) % 8;
        end
        #1;
    endtask

    initial begin
        logic r;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.out_ready = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_rr", 32'(bus.rr_ptr), 32'h0);
        reset = 1'b0;

        // Addressed load into lane 5.
        step(1'b1, 3'd5, 4'hA, 1'b0, 8'h00, r);
        check("addr_ready", 32'(r), 32'h1);
        step(1'b0, 3'd0, 4'h0, 1'b0, 8'h00, r);
        check("addr_valid", 32'(bus.out_valid), 32'h20);
        check("addr_data5", 32'(bus.out_data[5]), 32'hA);
        check("addr_pending", 32'(bus.pending), 32'h1);

        // Full lane blocks, then load-over-drain keeps it valid.
        step(1'b1, 3'd5, 4'h7, 1'b0, 8'h00, r);
        check("full_block", 32'(r), 32'h0);
        check("full_keep", 32'(bus.out_data[5]), 32'hA);
        step(1'b1, 3'd5, 4'h3, 1'b0, 8'h20, r);
        check("ld_drain_ready", 32'(r), 32'h1);
        check("ld_drain_valid", 32'(bus.out_valid), 32'h20);
        check("ld_drain_data", 32'(bus.out_data[5]), 32'h3);
        check("ld_drain_pending", 32'(bus.pending), 32'h1);

        // Round-robin over 10 words with every consumer ready.
        for (int k = 0; k < 10; k++) step(1'b1, 3'd0, 4'(k), 1'b1, 8'hFF, r);
        check("rr_wrap", 32'(bus.rr_ptr), 32'h2);
        check("rr_lane01", {24'h0, bus.out_data[1], bus.out_data[0]}, 32'h98);
        check("rr_lane7", 32'(bus.out_data[7]), 32'h7);

        // Bring pointer to 0, fill all lanes, verify no skip past lane 0.
        for (int k = 0; k < 6; k++) step(1'b1, 3'd0, 4'(k + 2), 1'b1, 8'hFF, r);
        step(1'b0, 3'd0, 4'h0, 1'b1, 8'hFF, r);
        for (int k = 0; k < 8; k++) step(1'b1, 3'd0, 4'(k + 4), 1'b1, 8'h00, r);
        check("all_full", 32'(bus.out_valid), 32'hFF);
        step(1'b1, 3'd0, 4'hF, 1'b1, 8'h00, r);
        check("stall_ready", 32'(r), 32'h0);
        check("stall_rr", 32'(bus.rr_ptr), 32'h0);
        step(1'b1, 3'd0, 4'hE, 1'b1, 8'h08, r);
        check("no_skip", 32'(r), 32'h0);
        check("no_skip_rr", 32'(bus.rr_ptr), 32'h0);

        // Fill lanes 1,4,6 with a non-zero pointer, then reset mid-cycle.
        step(1'b0, 3'd0, 4'h0, 1'b1, 8'hFF, r);
        step(1'b1, 3'd0, 4'h1, 1'b1, 8'hFF, r);
        step(1'b0, 3'd0, 4'h0, 1'b0, 8'hFF, r);
        step(1'b1, 3'd1, 4'h5, 1'b0, 8'h00, r);
        step(1'b1, 3'd4, 4'h6, 1'b0, 8'h00, r);
        step(1'b1, 3'd6, 4'h9, 1'b0, 8'h00, r);
        check("pre_rst_valid", 32'(bus.out_valid), 32'h52);
        check("pre_rst_rr", 32'(bus.rr_ptr), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(bus.out_valid), 32'h0);
        check("async_pending", 32'(bus.pending), 32'h0);
        check("async_rr", 32'(bus.rr_ptr), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 3'd2, 4'h6, 1'b0, 8'h00, r);
        step(1'b0, 3'd0, 4'h0, 1'b0, 8'h00, r);
        check("post_rst_valid", 32'(bus.out_valid), 32'h04);
        check("post_rst_data2", 32'(bus.out_data[2]), 32'h6);

        // Randomized traffic against the model and scoreboards.
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 8'($urandom), r);
        end
        step(1'b0, 3'd0, 4'h0, 1'b0, 8'hFF, r);
        step(1'b0, 3'd0, 4'h0, 1'b0, 8'h00, r);
        check("final_empty", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
